sap_ram_param: RTL
==================

Name: sap_ram_param

Overview:
- Parametrised successor of the SAP RAM/MAR block: DATA_W x 2^ADDR_W memory with an internal memory address register (MAR).
- Run mode: the control unit loads the MAR from the bus, writes bus data, or drives memory data onto the bus.
- Programming mode: dip switches and two debounced push buttons load the address and write data, with optional address auto-increment for fast front-panel entry.
- Sits on the shared 8-bit bus between the PC/IR/A-register blocks.

Parameters:
- ADDR_W, 4, MAR/address width; depth = 2**ADDR_W.
- DATA_W, 8, word and bus width.
- DEBOUNCE_CYCLES, 4, stable-high clk cycles a button must hold before it is accepted (>=1).

Ports:
- clk  in  1  system clock, rising edge.
- clear  in  1  asynchronous active-high reset.
- prog_mode  in  1  1=programming (switches), 0=run (bus); async, synchronised internally.
- auto_inc  in  1  programming mode: MAR+1 after each button write.
- dipswitch_addr  in  ADDR_W  switch address.
- dipswitch_data  in  DATA_W  switch data.
- addr_button  in  1  raw async button: load MAR from dipswitch_addr.
- write_button  in  1  raw async button: write dipswitch_data to mem[MAR].
- bus_in  in  DATA_W  bus value.
- load_addr_reg  in  1  run mode: MAR <= bus_in[ADDR_W-1:0].
- write_enable  in  1  run mode: mem[MAR] <= bus_in.
- output_enable  in  1  run mode: drive mem[MAR] onto bus_out.
- bus_out  out  DATA_W  mem[MAR] when output_enable and run mode, else 0.
- mar_out  out  ADDR_W  current MAR (LED display).
- mem_display  out  DATA_W  mem[MAR] always (LED display).

Behaviour:
- Clocking: one clock `clk`; reset `clear` is asynchronous and active-high.
- Reset values:
  - MAR=0, mar_out=0, bus_out=0.
  - Synchronisers and conditioner FSMs go to IDLE.
  - Memory contents are NOT cleared; mem_display follows mem[0].
- prog_mode: passed through a 2-flop synchroniser; mode_s is the synchronised value. All mode decisions use mode_s.
- Run mode (mode_s=0), acting on the clk edge:
  - load_addr_reg=1: MAR <= bus_in[ADDR_W-1:0].
  - write_enable=1: mem[MAR] <= bus_in, using the pre-edge MAR.
  - Both asserted: the write goes to the old MAR; the MAR takes the new address.
  - Buttons are ignored; their conditioners keep running but their pulses are discarded.
- bus_out: combinational, = mem[MAR] when output_enable & ~mode_s, else 0.
  - output_enable together with write_enable: bus_out shows the pre-write data until the edge.
- Programming mode (mode_s=1): load_addr_reg, write_enable and output_enable are ignored.
- Button conditioner, one per button, FSM with states:
  - IDLE -> CNT on sync_high.
  - CNT counts while sync_high; it returns to IDLE if the input drops before reaching DEBOUNCE_CYCLES.
  - At count==DEBOUNCE_CYCLES: emit a 1-cycle pulse and go to HELD.
  - HELD -> IDLE after the input has been low for DEBOUNCE_CYCLES consecutive cycles.
  - Exactly one pulse per press. Pulse latency = 2 sync cycles + DEBOUNCE_CYCLES after the first stable high.
- addr pulse: MAR <= dipswitch_addr.
- write pulse: mem[MAR] <= dipswitch_data; if auto_inc, MAR <= MAR+1, wrapping modulo 2**ADDR_W (all-ones -> 0).
- addr and write pulses in the same cycle:
  - the write targets dipswitch_addr;
  - MAR <= dipswitch_addr (+1 if auto_inc).
- Mode change: pulses arriving in the cycle mode_s changes are dropped. The MAR is preserved across mode changes.
- clear mid-press: the conditioner returns to IDLE. A button still held after release of clear must complete a full debounce and then produces one pulse.

Decomposition:
- Shared package/header sap_pkg:
  - conditioner state encodings (IDLE, CNT, HELD);
  - default widths SAP_ADDR_W=4, SAP_DATA_W=8.
- Sub-module sap_button_cond (DEBOUNCE_CYCLES parameter): 2-flop synchroniser, debounce counter, FSM, single-cycle pulse output. Instantiated twice.
- The memory array is inferred in the top module; no separate module.

Test Plan:
- Reset / run-mode store and read: clear pulse -> mar_out=0, bus_out=0. Run mode, bus_in=0x0A with load_addr_reg, then bus_in=0x5C with write_enable -> mem[0xA]=0x5C; output_enable -> bus_out=0x5C. Without output_enable -> bus_out=0.
- Programming auto-increment and wrap: prog_mode=1, auto_inc=1, dipswitch_addr=0xE, addr press, then two write presses with data 0x11 and 0x22 -> mem[0xE]=0x11, mem[0xF]=0x22, mar_out wraps to 0x0.
- Debounce rejection: DEBOUNCE_CYCLES=4, write_button high 3 cycles, low, then high 10 cycles -> exactly one write. A 20-cycle hold gives one pulse; a bounce during HELD gives no extra pulse.
- Simultaneous: run mode, MAR=3, load_addr_reg and write_enable with bus_in=0x07 -> mem[3]=0x07, MAR=7. Programming mode, both button pulses in the same cycle with addr=0x5, data=0x99, auto_inc=0 -> mem[5]=0x99, MAR=5.
- Mode isolation: prog_mode=1 with write_enable/output_enable toggling -> memory unchanged, bus_out=0. Run mode with write_button pressed -> memory unchanged.
- Async reset mid-press: clear asserted during CNT -> no pulse; MAR=0; memory contents retained.

Source files
------------

// File: rtl/sap_pkg.sv
// sap_pkg: shared widths and button-conditioner state encodings for the SAP RAM block.
package sap_pkg;
   localparam int SAP_ADDR_W = 4;
   localparam int SAP_DATA_W = 8;
   typedef enum logic [1:0] {ST_IDLE, ST_CNT, ST_HELD} cond_state_t;
endpackage

// File: rtl/sap_button_cond.sv
// sap_button_cond: synchronise a raw push button, debounce it and emit one pulse per press.
module sap_button_cond
   import sap_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_btn,
   output logic o_pulse
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] C_MAX = CW'(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] C_LOW = CW'(DEBOUNCE_CYCLES - 1);

   logic          r_s1, r_s2;
   cond_state_t   r_state, w_state_nxt;
   logic [CW-1:0] r_cnt, w_cnt_nxt;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_s1    <= 1'b0;
         r_s2    <= 1'b0;
         r_state <= ST_IDLE;
         r_cnt   <= '0;
      end else begin
         r_s1    <= i_btn;
         r_s2    <= r_s1;
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // r_cnt counts stable-high cycles in CNT and consecutive low cycles in HELD
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      o_pulse     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (r_s2) begin
               w_state_nxt = ST_CNT;
               w_cnt_nxt   = CW'(1);
            end
         end
         ST_CNT: begin
            if (r_cnt == C_MAX) begin
               o_pulse     = 1'b1;
               w_state_nxt = ST_HELD;
               w_cnt_nxt   = '0;
            end else if (!r_s2) begin
               w_state_nxt = ST_IDLE;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         ST_HELD: begin
            if (r_s2) begin
               w_cnt_nxt = '0;
            end else if (r_cnt == C_LOW) begin
               w_state_nxt = ST_IDLE;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end
endmodule

// File: rtl/sap_ram_param.sv
// sap_ram_param: SAP RAM with internal MAR, bus-driven run mode and front-panel programming mode.
module sap_ram_param
   import sap_pkg::*;
#(
   parameter int ADDR_W          = SAP_ADDR_W,
   parameter int DATA_W          = SAP_DATA_W,
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic              clk,
   input  logic              clear,
   input  logic              prog_mode,
   input  logic              auto_inc,
   input  logic [ADDR_W-1:0] dipswitch_addr,
   input  logic [DATA_W-1:0] dipswitch_data,
   input  logic              addr_button,
   input  logic              write_button,
   input  logic [DATA_W-1:0] bus_in,
   input  logic              load_addr_reg,
   input  logic              write_enable,
   input  logic              output_enable,
   output logic [DATA_W-1:0] bus_out,
   output logic [ADDR_W-1:0] mar_out,
   output logic [DATA_W-1:0] mem_display
);
   logic [DATA_W-1:0] r_mem [0:(2**ADDR_W)-1];
   logic [ADDR_W-1:0] r_mar;
   logic              r_mode_m, r_mode_s, r_mode_d;
   logic              w_addr_pulse, w_wr_pulse;
   logic              w_prog, w_run, w_addr_p, w_wr_p, w_we;
   logic [ADDR_W-1:0] w_waddr, w_mar_base, w_mar_nxt;
   logic [DATA_W-1:0] w_wdata;

   sap_button_cond #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_addr_cond (
      .i_clk(clk), .i_rst(clear), .i_btn(addr_button), .o_pulse(w_addr_pulse)
   );

   sap_button_cond #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_wr_cond (
      .i_clk(clk), .i_rst(clear), .i_btn(write_button), .o_pulse(w_wr_pulse)
   );

   // button pulses are only honoured once the synchronised mode has been stable for a cycle
   assign w_run    = ~r_mode_s;
   assign w_prog   = r_mode_s & r_mode_d;
   assign w_addr_p = w_prog & w_addr_pulse;
   assign w_wr_p   = w_prog & w_wr_pulse;

   assign w_mar_base = w_addr_p ? dipswitch_addr : r_mar;
   assign w_waddr    = w_wr_p ? w_mar_base : r_mar;
   assign w_wdata    = w_wr_p ? dipswitch_data : bus_in;
   assign w_we       = w_wr_p | (w_run & write_enable);
   assign w_mar_nxt  = w_run ? (load_addr_reg ? bus_in[ADDR_W-1:0] : r_mar)
                             : ((w_wr_p & auto_inc) ? w_mar_base + 1'b1 : w_mar_base);

   always_ff @(posedge clk or posedge clear) begin
      if (clear) begin
         r_mode_m <= 1'b0;
         r_mode_s <= 1'b0;
         r_mode_d <= 1'b0;
         r_mar    <= '0;
      end else begin
         r_mode_m <= prog_mode;
         r_mode_s <= r_mode_m;
         r_mode_d <= r_mode_s;
         r_mar    <= w_mar_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (w_we) r_mem[w_waddr] <= w_wdata;
   end

   assign mar_out     = r_mar;
   assign mem_display = r_mem[r_mar];
   assign bus_out     = (output_enable & w_run) ? r_mem[r_mar] : '0;
endmodule
